move_sequencer: RTL and testbench
=================================

Name: move_sequencer

Overview:
- Sits directly downstream of the setup-move generator and consumes its 60-bit packed move word (15 nibbles) plus the `new_moves` strobe.
- Holds one active batch and one pending batch, and unpacks each batch into single 4-bit move codes.
- Issues each code to the motor driver over a valid/ready handshake, waits for motor completion and inserts a settle gap so the camera can observe.
- Pulses `batch_done` back upstream to advance the observation counter.

Parameters:
- SETTLE_CYCLES, 16, idle cycles after each completed move before the next one is issued (≥1).
- TIMEOUT_CYCLES, 1000000, maximum cycles to wait for `move_done` before faulting (≥2).

Ports:
- `clock`  in  1  system clock, rising-edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `moves`  in  60  packed move codes; nibble 14 = `moves[59:56]` is issued first, nibble 0 last.
- `new_moves`  in  1  1-cycle strobe; `moves` is valid when high.
- `move_code`  out  4  current move (1=R, 2=R', 3=U, 4=U', 5=F, 6=F', 7=L, 8=L', 9=B, 10=B', 11=D, 12=D').
- `move_valid`  out  1  `move_code` offered to the motor driver.
- `move_ready`  in  1  driver accepts when `move_valid && move_ready`.
- `move_done`  in  1  1-cycle pulse: accepted move has finished rotating.
- `fault_clr`  in  1  clears FAULT state and sticky flags.
- `busy`  out  1  high whenever state != IDLE or any buffer is valid.
- `batch_done`  out  1  1-cycle pulse when a batch has been fully executed.
- `overflow`  out  1  sticky: batch dropped because both buffers were full.
- `bad_code`  out  1  sticky: nibble 13–15 encountered; that nibble was skipped.
- `fault`  out  1  high in FAULT (move timeout).

Behaviour:
- Reset (async, `reset_n`=0): state=IDLE; both buffers invalid; `move_code`=0; `move_valid`, `batch_done`, `overflow`, `bad_code`, `fault`=0; index=14; timers=0.
- Capture, evaluated every cycle, after FINISH promotion:
  - On `new_moves`: if active is free, load active.
  - Else if pending is free, load pending.
  - Else drop the batch and set `overflow`.
  - An all-zero word is accepted and yields a `batch_done` with no moves issued.
- States:
  - IDLE: if active valid, set index=14 and go to SCAN.
  - SCAN: examine nibble[index], one nibble per cycle.
    - Codes 1–12: latch `move_code`, go to ISSUE.
    - Code 0: skip.
    - Codes 13–15: set `bad_code` and skip.
    - On skip: if index==0 go to FINISH, else decrement index.
  - ISSUE: `move_valid`=1 and `move_code` held stable until `move_ready` is sampled high. Then drop `move_valid`, clear the timer, go to WAIT_DONE.
  - WAIT_DONE: count cycles.
    - On `move_done`, go to SETTLE.
    - If the count reaches TIMEOUT_CYCLES with no `move_done`, go to FAULT.
  - SETTLE: wait exactly SETTLE_CYCLES cycles. Then, if index==0 go to FINISH, else decrement index and go to SCAN.
  - FINISH (1 cycle): `batch_done`=1; active invalidated. If pending is valid, promote it to active in the same cycle. Go to IDLE.
  - FAULT: `fault`=1; both buffers invalidated; `new_moves` ignored; `move_valid`=0. `fault_clr` returns to IDLE and clears `fault`, `overflow` and `bad_code`.
- `fault_clr` outside FAULT clears only `overflow` and `bad_code`.
- Latency:
  - `new_moves` into an empty, idle block: `move_valid` rises 3 cycles after the strobe edge (capture, IDLE→SCAN, SCAN→ISSUE), assuming nibble 14 is nonzero.
  - Each leading zero nibble adds 1 cycle.
- `move_done` outside WAIT_DONE is ignored.
- `move_ready` outside ISSUE is ignored.
- Simultaneous FINISH and `new_moves` with pending valid: pending is promoted to active, and the incoming word loads pending. No overflow.
- `reset_n` asserted mid-move: all state is lost immediately and `move_valid` drops asynchronously.

Test Plan:
- `moves`=60'h00000000000035A, `new_moves` pulse, `move_ready`=1, `move_done` 5 cycles after each accept, SETTLE_CYCLES=4 → codes 3, 5, 10 issued in that order, then one `batch_done` pulse; `overflow`=0, `bad_code`=0.
- `moves`=0 strobe → no `move_valid`; `batch_done` pulses once; `busy` returns to 0.
- Three strobes back-to-back while the first batch is running → batches 1 and 2 executed in order, batch 3 dropped, `overflow`=1 until `fault_clr`.
- `moves`=60'h0000000000000E3 → `bad_code`=1; only code 3 issued; `batch_done` pulses.
- TIMEOUT_CYCLES=20, `move_done` never asserted → `fault`=1 at 20 cycles after accept; later strobes ignored; `fault_clr` → IDLE with `fault`=0 and `busy`=0.
- `move_ready` held low for 10 cycles → `move_valid` and `move_code` stay stable for all 10 cycles; exactly one transfer occurs when `move_ready` rises.

Source files
------------

// File: rtl/move_sequencer_if.sv
// Motor-driver handshake: one 4-bit move code offered with valid/ready,
// followed later by a single-cycle completion pulse from the driver.
interface move_sequencer_if;
  logic [3:0] move_code;
  logic       move_valid;
  logic       move_ready;
  logic       move_done;

  modport master (
    output move_code,
    output move_valid,
    input  move_ready,
    input  move_done
  );

  modport slave (
    input  move_code,
    input  move_valid,
    output move_ready,
    output move_done
  );
endinterface

// File: rtl/move_sequencer.sv
// Unpacks 15-nibble move batches into single move codes and sequences them
// to the motor driver: issue, wait for completion, settle, next nibble.
// Two batch buffers (active + pending) let the next batch queue up while
// the current one is running.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for the active buffer to become valid
// SCAN      | inspect nibble[idx]; skip 0 and 13-15, latch 1-12
// ISSUE     | move_valid high until the driver takes the code
// WAIT_DONE | timeout down-counter running, waiting for move_done
// SETTLE    | settle down-counter running, camera observes the cube
// FINISH    | one-cycle batch_done; pending promoted into active
// FAULT     | move timed out; buffers flushed until fault_clr
module move_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [59:0]             moves,
  input  logic                    new_moves,
  move_sequencer_if.master        mv,
  input  logic                    fault_clr,
  output logic                    busy,
  output logic                    batch_done,
  output logic                    overflow,
  output logic                    bad_code,
  output logic                    fault
);

  localparam int unsigned TMAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int TW = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_ISSUE, S_WAIT_DONE, S_SETTLE, S_FINISH, S_FAULT
  } state_t;

  state_t         state, state_nxt;
  logic [3:0]     idx, idx_nxt;
  logic [TW-1:0]  timer, timer_nxt;
  logic [3:0]     code_q, code_nxt;
  logic           act_v, act_v_nxt, pend_v, pend_v_nxt;
  logic [59:0]    act_w, act_w_nxt, pend_w, pend_w_nxt;
  logic           ovf_nxt, bad_nxt;
  logic [3:0]     nib;

  assign nib           = act_w[{idx, 2'b00} +: 4];
  assign mv.move_code  = code_q;
  assign mv.move_valid = (state == S_ISSUE);
  assign batch_done    = (state == S_FINISH);
  assign fault         = (state == S_FAULT);
  assign busy          = (state != S_IDLE) || act_v || pend_v;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state, datapath next values and batch capture (capture sees the
  // buffers after any FINISH promotion, so a strobe in FINISH never drops).
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    timer_nxt  = timer;
    code_nxt   = code_q;
    act_v_nxt  = act_v;
    act_w_nxt  = act_w;
    pend_v_nxt = pend_v;
    pend_w_nxt = pend_w;
    ovf_nxt    = overflow & ~fault_clr;
    bad_nxt    = bad_code & ~fault_clr;

    case (state)
      S_IDLE: begin
        if (act_v) begin
          idx_nxt   = 4'd14;
          state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (nib >= 4'd1 && nib <= 4'd12) begin
          code_nxt  = nib;
          state_nxt = S_ISSUE;
        end else begin
          if (nib != 4'd0) bad_nxt = 1'b1;
          if (idx == 4'd0) state_nxt = S_FINISH;
          else             idx_nxt   = idx - 4'd1;
        end
      end
      S_ISSUE: begin
        if (mv.move_ready) begin
          timer_nxt = TW'(TIMEOUT_CYCLES - 1);
          state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (mv.move_done) begin
          timer_nxt = TW'(SETTLE_CYCLES - 1);
          state_nxt = S_SETTLE;
        end else if (timer == '0) begin
          state_nxt = S_FAULT;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      S_SETTLE: begin
        if (timer == '0) begin
          if (idx == 4'd0) begin
            state_nxt = S_FINISH;
          end else begin
            idx_nxt   = idx - 4'd1;
            state_nxt = S_SCAN;
          end
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      S_FINISH: begin
        act_v_nxt  = pend_v;
        act_w_nxt  = pend_w;
        pend_v_nxt = 1'b0;
        state_nxt  = S_IDLE;
      end
      S_FAULT: begin
        act_v_nxt  = 1'b0;
        pend_v_nxt = 1'b0;
        if (fault_clr) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (new_moves && state != S_FAULT) begin
      if (!act_v_nxt) begin
        act_v_nxt = 1'b1;
        act_w_nxt = moves;
      end else if (!pend_v_nxt) begin
        pend_v_nxt = 1'b1;
        pend_w_nxt = moves;
      end else begin
        ovf_nxt = 1'b1;
      end
    end
  end

  // Datapath registers: index, shared down-counter, code latch, buffers, flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx      <= 4'd14;
      timer    <= '0;
      code_q   <= 4'd0;
      act_v    <= 1'b0;
      act_w    <= '0;
      pend_v   <= 1'b0;
      pend_w   <= '0;
      overflow <= 1'b0;
      bad_code <= 1'b0;
    end else begin
      idx      <= idx_nxt;
      timer    <= timer_nxt;
      code_q   <= code_nxt;
      act_v    <= act_v_nxt;
      act_w    <= act_w_nxt;
      pend_v   <= pend_v_nxt;
      pend_w   <= pend_w_nxt;
      overflow <= ovf_nxt;
      bad_code <= bad_nxt;
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: directed steps plus random batches, checked
// against a nibble-list model of each batch and a simple motor driver.
module tb_move_sequencer;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 20;
  localparam int DONE_DLY = 5;
  // accept -> done after DONE_DLY, SETTLE idle cycles, one SCAN, one ISSUE edge
  localparam int GAP = DONE_DLY + SETTLE + 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [59:0] moves;
  logic        new_moves;
  logic        fault_clr;
  logic        busy, batch_done, overflow, bad_code, fault;

  move_sequencer_if mv ();

  move_sequencer #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n), .moves(moves), .new_moves(new_moves),
    .mv(mv), .fault_clr(fault_clr), .busy(busy), .batch_done(batch_done),
    .overflow(overflow), .bad_code(bad_code), .fault(fault)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // driver/monitor configuration (written by the main sequence only)
  bit done_en = 1'b1, done_rand = 1'b0, rand_ready = 1'b0, mon_en = 1'b1;
  int hold_len = 0;
  // driver/monitor state (written by the monitor only)
  int hold_used = 0, done_wait = 0, bd_cnt = 0, vcnt = 0, stall_cnt = 0, stab_err = 0;
  logic [3:0] got[$];
  int acc_q[$];
  logic p_valid = 1'b0, p_ready = 1'b0, nr;
  logic [3:0] p_code = 4'd0;

  logic [3:0] exp_q[$];
  logic exp_bad;

  always @(posedge clock) cyc++;

  // Motor driver and monitor, all on the falling edge.
  always @(negedge clock) begin
    mv.move_done = 1'b0;
    if (done_wait > 0) begin
      done_wait--;
      if (done_wait == 0 && done_en) mv.move_done = 1'b1;
    end
    if (hold_used < hold_len) begin
      nr = 1'b0;
      if (mv.move_valid) hold_used++;
    end else if (rand_ready) begin
      nr = 1'($urandom_range(0, 1));
    end else begin
      nr = 1'b1;
    end
    mv.move_ready = nr;
    if (mon_en) begin
      if (p_valid && !p_ready && (mv.move_valid !== 1'b1 || mv.move_code !== p_code)) stab_err++;
      if (mv.move_valid) vcnt++;
      if (mv.move_valid && !nr) stall_cnt++;
      if (mv.move_valid && nr) begin
        got.push_back(mv.move_code);
        acc_q.push_back(cyc);
        done_wait = done_rand ? int'($urandom_range(1, 6)) : DONE_DLY;
      end
      if (batch_done) bd_cnt++;
    end
    p_valid = mv.move_valid;
    p_ready = nr;
    p_code  = mv.move_code;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a batch is the list of codes 1..12 read nibble 14 down to 0;
  // any nibble 13..15 marks the batch as carrying a bad code.
  function automatic void model_batch(input logic [59:0] w);
    for (int i = 14; i >= 0; i--) begin
      int n = int'((w >> (4 * i)) & 60'hF);
      if (n >= 1 && n <= 12) exp_q.push_back(4'(n));
      else if (n >= 13) exp_bad = 1'b1;
    end
  endfunction

  function automatic logic [59:0] rand_word(input bit allow_bad);
    logic [59:0] w = '0;
    for (int i = 0; i < 15; i++) begin
      int r = int'($urandom_range(0, 9));
      logic [3:0] c;
      if (r < 3) c = 4'($urandom_range(1, 12));
      else if (r == 3 && allow_bad) c = 4'($urandom_range(13, 15));
      else c = 4'd0;
      w[4*i +: 4] = c;
    end
    return w;
  endfunction

  task automatic check_codes(input string tag, input int g0);
    check({tag, "_count"}, 64'(got.size() - g0), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++)
      check(tag, 64'(got[g0 + i]), 64'(exp_q[i]));
    exp_q.delete();
  endtask

  task automatic strobe(input logic [59:0] w);
    moves = w;
    new_moves = 1'b1;
    @(negedge clock);
    new_moves = 1'b0;
  endtask

  task automatic clr_pulse();
    fault_clr = 1'b1;
    @(negedge clock);
    fault_clr = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  logic [59:0] w, wa, wb, wc;
  int g0, b0, v0, s0;

  initial begin
    reset_n = 1'b0; moves = '0; new_moves = 1'b0; fault_clr = 1'b0; exp_bad = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_valid", 64'(mv.move_valid), 0);
    check("rst_code", 64'(mv.move_code), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_batch_done", 64'(batch_done), 0);
    check("rst_overflow", 64'(overflow), 0);
    check("rst_bad_code", 64'(bad_code), 0);
    check("rst_fault", 64'(fault), 0);
    reset_n = 1'b1;
    @(negedge clock);

    // directed batch 3,5,10 with fixed completion delay
    w = 60'h00000000000035A; g0 = got.size(); b0 = bd_cnt; exp_bad = 1'b0;
    model_batch(w); strobe(w); wait_idle("t1");
    check_codes("t1_codes", g0);
    check("t1_batch_done", 64'(bd_cnt - b0), 1);
    check("t1_overflow", 64'(overflow), 0);
    check("t1_bad_code", 64'(bad_code), 0);
    for (int i = g0 + 1; i < acc_q.size(); i++)
      check("t1_issue_gap", 64'(acc_q[i] - acc_q[i-1]), 64'(GAP));

    // first-issue latency: 3 edges, plus one per leading zero nibble
    w = {4'd1, 56'd0}; g0 = got.size(); exp_bad = 1'b0; model_batch(w);
    strobe(w);
    check("lat0_c1", 64'(mv.move_valid), 0);
    @(negedge clock); check("lat0_c2", 64'(mv.move_valid), 0);
    @(negedge clock); check("lat0_c3", 64'(mv.move_valid), 1);
    wait_idle("lat0"); check_codes("lat0_codes", g0);
    w = {8'd0, 4'd7, 48'd0}; g0 = got.size(); model_batch(w);
    strobe(w);
    repeat (3) @(negedge clock); check("lat2_c4", 64'(mv.move_valid), 0);
    @(negedge clock); check("lat2_c5", 64'(mv.move_valid), 1);
    check("lat2_code", 64'(mv.move_code), 7);
    wait_idle("lat2"); check_codes("lat2_codes", g0);

    // all-zero batch
    g0 = got.size(); b0 = bd_cnt; v0 = vcnt;
    strobe(60'h0); wait_idle("zero");
    check("zero_no_valid", 64'(vcnt - v0), 0);
    check("zero_batch_done", 64'(bd_cnt - b0), 1);

    // three strobes back to back: two run in order, third dropped
    wa = rand_word(1'b0) | 60'h1; wb = rand_word(1'b0) | 60'h2; wc = rand_word(1'b0) | 60'h3;
    g0 = got.size(); b0 = bd_cnt; exp_bad = 1'b0;
    model_batch(wa); model_batch(wb);
    strobe(wa); strobe(wb); strobe(wc);
    check("ovf_set", 64'(overflow), 1);
    wait_idle("ovf");
    check_codes("ovf_codes", g0);
    check("ovf_batch_done", 64'(bd_cnt - b0), 2);
    check("ovf_sticky", 64'(overflow), 1);
    clr_pulse();
    check("ovf_cleared", 64'(overflow), 0);

    // bad code nibble skipped
    w = 60'h0000000000000E3; g0 = got.size(); b0 = bd_cnt; exp_bad = 1'b0;
    model_batch(w); strobe(w); wait_idle("bad");
    check_codes("bad_codes", g0);
    check("bad_flag", 64'(bad_code), 64'(exp_bad));
    check("bad_batch_done", 64'(bd_cnt - b0), 1);
    clr_pulse();
    check("bad_cleared", 64'(bad_code), 0);

    // random batches, random ready and completion delay
    rand_ready = 1'b1; done_rand = 1'b1;
    for (int k = 0; k < 6; k++) begin
      w = rand_word(k[0]); g0 = got.size(); b0 = bd_cnt; exp_bad = 1'b0;
      model_batch(w); strobe(w); wait_idle("rand");
      check_codes("rand_codes", g0);
      check("rand_batch_done", 64'(bd_cnt - b0), 1);
      check("rand_bad", 64'(bad_code), 64'(exp_bad));
      clr_pulse();
    end
    rand_ready = 1'b0; done_rand = 1'b0;
    check("rand_stability", 64'(stab_err), 0);

    // ready held low for 10 offered cycles
    g0 = got.size(); s0 = stall_cnt; exp_bad = 1'b0;
    hold_len = hold_used + 10;
    w = 60'h000000000000009; model_batch(w); strobe(w); wait_idle("hold");
    check_codes("hold_codes", g0);
    check("hold_stalls", 64'(stall_cnt - s0), 10);
    check("hold_stable", 64'(stab_err), 0);

    // completion timeout
    done_en = 1'b0; g0 = got.size();
    strobe(60'h1);
    begin
      int n = 0;
      while (fault !== 1'b1 && n < 500) begin
        @(negedge clock);
        n++;
      end
    end
    check("to_fault", 64'(fault), 1);
    check("to_latency", 64'(cyc - acc_q[acc_q.size()-1]), 64'(TIMEOUT + 1));
    strobe(60'h5); strobe(60'h6); repeat (5) @(negedge clock);
    check("to_ignored", 64'(got.size() - g0), 1);
    check("to_valid_low", 64'(mv.move_valid), 0);
    check("to_still_fault", 64'(fault), 1);
    clr_pulse();
    check("to_clr_fault", 64'(fault), 0);
    check("to_clr_busy", 64'(busy), 0);
    repeat (10) @(negedge clock);
    check("to_no_issue", 64'(got.size() - g0), 1);
    done_en = 1'b1;

    // reset while a move is offered
    hold_len = hold_used + 5;
    strobe({4'd2, 56'd0});
    begin
      int n = 0;
      while (mv.move_valid !== 1'b1 && n < 50) begin
        @(negedge clock);
        n++;
      end
    end
    check("rstmid_valid_before", 64'(mv.move_valid), 1);
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rstmid_valid", 64'(mv.move_valid), 0);
    check("rstmid_busy", 64'(busy), 0);
    check("rstmid_code", 64'(mv.move_code), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
